// File: rtl/bg_scroll_buffer.sv
// bg_scroll_buffer: banked background image store with wrapped
// horizontal scroll and a 3-stage upscaled read pipeline.
module bg_scroll_buffer #(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int DATA_W      = 16,
  parameter int BANKS       = 2,
  parameter int ADDR_W      = 15,
  parameter int STEP_W      = 8,
  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int SW = $clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BW-1:0]     wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BW-1:0]     bank_sel,
  input  logic              scroll_en,
  input  logic [STEP_W-1:0] scroll_step,
  input  logic              frame_tick,
  input  logic [9:0]        px_x,
  input  logic [9:0]        px_y,
  input  logic              px_valid,
  output logic [DATA_W-1:0] pix_out,
  output logic              pix_valid,
  output logic [SW-1:0]     scroll_pos
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int DEPTH = BANKS * NPIX;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(IMG_W - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [BW-1:0]     bank_q;
  logic [BW-1:0]     bank_eff;
  logic [STEP_W-1:0] step_c;
  logic [SW:0]       sum_raw;
  logic [SW:0]       sum_wrap;

  logic              s1_v;
  logic              s1_oob;
  logic [9:0]        s1_x;
  logic [9:0]        s1_y;
  logic              s2_v;
  logic              s2_oob;
  logic [AW-1:0]     s2_a;

  logic [9:0]        sx;
  logic [9:0]        sy;
  logic [10:0]       col_raw;
  logic [10:0]       col;
  logic [AW-1:0]     addr_c;
  logic [AW-1:0]     waddr;
  logic              wr_ok;

  assign bank_eff = (BANKS > 1) ? bank_q : '0;

  always_comb begin
    step_c   = (scroll_step > STEP_MAX) ? STEP_MAX : scroll_step;
    sum_raw  = {1'b0, scroll_pos} + (SW+1)'(step_c);
    sum_wrap = sum_raw;
    if (sum_raw >= (SW+1)'(IMG_W))
      sum_wrap = sum_raw - (SW+1)'(IMG_W);
  end

  assign sx = px_x >> SCALE_SHIFT;
  assign sy = px_y >> SCALE_SHIFT;

  // Column wraps with a single subtract since both terms are below IMG_W
  always_comb begin
    col_raw = {1'b0, s1_x} + 11'(scroll_pos);
    col     = col_raw;
    if (col_raw >= 11'(IMG_W))
      col = col_raw - 11'(IMG_W);
    addr_c = AW'(bank_eff) * AW'(NPIX)
           + AW'(s1_y) * AW'(IMG_W)
           + AW'(col);
  end

  assign wr_ok = wr_en
              && ({1'b0, wr_addr} < (ADDR_W+1)'(NPIX))
              && ((BANKS > 1) || (wr_bank == '0));
  assign waddr = AW'(wr_bank) * AW'(NPIX) + AW'(wr_addr);

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[waddr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q     <= '0;
      scroll_pos <= '0;
      s1_v       <= 1'b0;
      s1_oob     <= 1'b0;
      s1_x       <= '0;
      s1_y       <= '0;
      s2_v       <= 1'b0;
      s2_oob     <= 1'b0;
      s2_a       <= '0;
      pix_valid  <= 1'b0;
      pix_out    <= '0;
    end else begin
      if (frame_tick) begin
        bank_q <= bank_sel;
        if (scroll_en)
          scroll_pos <= SW'(sum_wrap);
      end
      s1_v   <= px_valid;
      s1_x   <= sx;
      s1_y   <= sy;
      s1_oob <= (sx >= 10'(IMG_W)) || (sy >= 10'(IMG_H));
      s2_v   <= s1_v;
      s2_oob <= s1_oob;
      s2_a   <= s1_oob ? '0 : addr_c;
      pix_valid <= s2_v;
      if (s2_v)
        pix_out <= s2_oob ? '0 : mem[s2_a];
    end
  end

endmodule

// File: tb/tb_bg_scroll_buffer.sv
// tb_bg_scroll_buffer: random and directed stimulus against a
// queue-style reference model of the scrolled, banked image.
module tb_bg_scroll_buffer;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int NP = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [0:0]  wr_bank;
  logic [14:0] wr_addr;
  logic [15:0] wr_data;
  logic [0:0]  bank_sel;
  logic        scroll_en;
  logic [7:0]  scroll_step;
  logic        frame_tick;
  logic [9:0]  px_x;
  logic [9:0]  px_y;
  logic        px_valid;
  logic [15:0] pix_out;
  logic        pix_valid;
  logic [7:0]  scroll_pos;

  int checks = 0;
  int failures = 0;

  logic [15:0] mm [2*NP];
  int          sc_m;
  int          bk_m;
  bit          ev;
  logic [15:0] eo;
  bit          p1v, p2v, p1o, p2o;
  int          p1a, p2a;

  bg_scroll_buffer dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .bank_sel(bank_sel), .scroll_en(scroll_en),
    .scroll_step(scroll_step), .frame_tick(frame_tick),
    .px_x(px_x), .px_y(px_y), .px_valid(px_valid),
    .pix_out(pix_out), .pix_valid(pix_valid),
    .scroll_pos(scroll_pos)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string n, input logic [15:0] a,
                     input logic [15:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  // Pixel sampled at this edge sees post-edge scroll/bank; its
  // memory read happens two edges later, before that edge's write.
  task automatic model_step();
    int sx, sy, st;
    if (rst) begin
      ev = 0; eo = 16'h0; p1v = 0; p2v = 0;
      sc_m = 0; bk_m = 0;
    end else begin
      ev = p2v;
      if (p2v) eo = p2o ? 16'h0 : mm[p2a];
      p2v = p1v; p2o = p1o; p2a = p1a;
      if (frame_tick) begin
        bk_m = int'(bank_sel);
        st = int'(scroll_step);
        if (st > W - 1) st = W - 1;
        if (scroll_en) sc_m = (sc_m + st) % W;
      end
      sx = int'(px_x) >> 2;
      sy = int'(px_y) >> 2;
      p1v = px_valid;
      p1o = (sx >= W) || (sy >= H);
      p1a = p1o ? 0 : bk_m * NP + sy * W + (sx + sc_m) % W;
    end
    if (wr_en && int'(wr_addr) < NP)
      mm[int'(wr_bank) * NP + int'(wr_addr)] = wr_data;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    cmp("model_valid", 16'(pix_valid), 16'(ev));
    cmp("model_pix", pix_out, eo);
    cmp("model_scroll", 16'(scroll_pos), 16'(sc_m));
  endtask

  task automatic rd(input int x, input int y, input bit ft);
    px_x = 10'(x); px_y = 10'(y); px_valid = 1'b1;
    frame_tick = ft;
    cyc();
    px_valid = 1'b0; frame_tick = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic tick(input int step);
    scroll_en = 1'b1; scroll_step = 8'(step); frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_bank = '0; wr_addr = '0;
    wr_data = '0; bank_sel = '0; scroll_en = 1'b0;
    scroll_step = '0; frame_tick = 1'b0;
    px_x = '0; px_y = '0; px_valid = 1'b0;
    cyc();
    cyc();
    cmp("reset_valid", 16'(pix_valid), 16'h0);
    cmp("reset_pix", pix_out, 16'h0);
    cmp("reset_scroll", 16'(scroll_pos), 16'h0);
    rst = 1'b0;

    for (int b = 0; b < 2; b++)
      for (int a = 0; a < NP; a++) begin
        wr_en = 1'b1; wr_bank = 1'(b); wr_addr = 15'(a);
        wr_data = (b == 1) ? ~16'(a) : 16'(a);
        cyc();
      end
    wr_en = 1'b0;

    rd(8, 4, 1'b0);
    cmp("px_8_4", pix_out, 16'h00A2);
    cmp("px_8_4_valid", 16'(pix_valid), 16'h1);
    cyc();
    cmp("valid_falls", 16'(pix_valid), 16'h0);
    cmp("pix_holds", pix_out, 16'h00A2);

    for (int i = 0; i < 64; i++) begin
      px_x = 10'(i * 4); px_y = 10'(8 + i); px_valid = 1'(i % 5 != 0);
      cyc();
    end
    px_valid = 1'b0;

    for (int i = 0; i < 8; i++) tick(20);
    cmp("scroll_8x20", 16'(scroll_pos), 16'd0);
    tick(150);
    tick(20);
    cmp("scroll_wrap_10", 16'(scroll_pos), 16'd10);
    tick(140);
    rd(40, 0, 1'b0);
    cmp("scroll_col0", pix_out, 16'h0000);
    tick(255);
    cmp("scroll_clamp", 16'(scroll_pos), 16'd149);
    tick(11);
    cmp("scroll_back0", 16'(scroll_pos), 16'd0);
    scroll_en = 1'b0;

    bank_sel = 1'b1;
    rd(0, 0, 1'b0);
    cmp("bank_no_tick", pix_out, 16'h0000);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    rd(0, 0, 1'b0);
    cmp("bank1_px00", pix_out, 16'hFFFF);
    bank_sel = 1'b0;
    rd(1, 0, 1'b1);
    cmp("tick_coincide", pix_out, 16'h0000);

    rd(0, 480, 1'b0);
    cmp("oob_pix", pix_out, 16'h0000);
    cmp("oob_valid", 16'(pix_valid), 16'h1);
    wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 15'(NP); wr_data = 16'hBEEF;
    cyc();
    wr_en = 1'b0;
    bank_sel = 1'b1;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    rd(0, 0, 1'b0);
    cmp("oob_write_ignored", pix_out, 16'hFFFF);

    px_x = 10'd20; px_y = 10'd0; px_valid = 1'b1;
    cyc();
    px_valid = 1'b0;
    cyc();
    wr_en = 1'b1; wr_bank = 1'b1; wr_addr = 15'd5; wr_data = 16'h1234;
    cyc();
    wr_en = 1'b0;
    cmp("rdw_old", pix_out, 16'hFFFA);
    rd(20, 0, 1'b0);
    cmp("rdw_new", pix_out, 16'h1234);

    tick(37);
    scroll_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      px_x = 10'(i * 8); px_y = 10'd12; px_valid = 1'b1;
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0; px_valid = 1'b0;
    cmp("mid_rst_valid", 16'(pix_valid), 16'h0);
    cmp("mid_rst_pix", pix_out, 16'h0);
    cmp("mid_rst_scroll", 16'(scroll_pos), 16'h0);
    cyc();
    cmp("mid_rst_flush", 16'(pix_valid), 16'h0);
    rd(8, 4, 1'b0);
    cmp("mem_intact", pix_out, 16'h00A2);

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_bank = 1'($urandom);
      wr_addr = ($urandom_range(0, 9) == 0)
              ? 15'($urandom_range(NP, 32767))
              : 15'($urandom_range(0, NP - 1));
      wr_data = 16'($urandom);
      bank_sel = 1'($urandom);
      scroll_en = 1'($urandom);
      scroll_step = 8'($urandom);
      frame_tick = ($urandom_range(0, 15) == 0);
      px_x = 10'($urandom_range(0, 700));
      px_y = 10'($urandom_range(0, 520));
      px_valid = ($urandom_range(0, 3) != 0);
      cyc();
    end
    rst = 1'b0; wr_en = 1'b0; frame_tick = 1'b0; px_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bg_scroll_buffer.md
# bg_scroll_buffer

Parametrised, dual-bank background image buffer with horizontal scrolling and integer upscaling, feeding the VGA pixel pipeline. It stores BANKS background images (e.g. day/night) of IMG_W x IMG_H pixels, accepts run-time writes, and returns the pixel for any screen coordinate after a fixed 3-cycle latency. The horizontal scroll offset wraps modulo IMG_W and advances once per frame. Bank switches are applied only at frame boundaries, so a frame never shows a mix of banks.

## Interface
- IMG_W, 160, image width in pixels
- IMG_H, 120, image height in pixels
- SCALE_SHIFT, 2, screen-to-image downscale as a shift (2 → 640x480 screen)
- DATA_W, 16, pixel word width
- BANKS, 2, number of image banks (power of 2, ≥1)
- ADDR_W, 15, per-bank address width (2^ADDR_W ≥ IMG_W*IMG_H)
- STEP_W, 8, scroll step width

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe
- wr_bank  in  log2(BANKS) (min 1)  target bank of the write
- wr_addr  in  ADDR_W  linear address within the bank, row*IMG_W + col
- wr_data  in  DATA_W  pixel to write
- bank_sel  in  log2(BANKS) (min 1)  requested display bank
- scroll_en  in  1  enables scroll advance
- scroll_step  in  STEP_W  pixels to advance per frame
- frame_tick  in  1  one-cycle pulse at the start of vertical blank
- px_x, px_y  in  10 each  screen coordinate
- px_valid  in  1  coordinate valid
- pix_out  out  DATA_W  pixel data
- pix_valid  out  1  pix_out valid
- scroll_pos  out  log2(IMG_W)  current scroll offset

## Operation
- Memory holds BANKS*IMG_W*IMG_H words. Memory contents are not affected by reset.
- Writes:
  - A write with wr_addr ≥ IMG_W*IMG_H is ignored.
  - Otherwise the word is written in the same edge.
- On frame_tick:
  - The active bank is loaded from bank_sel.
  - If scroll_en is high, scroll_pos is updated to (scroll_pos + min(scroll_step, IMG_W-1)) mod IMG_W.
  - Wrap uses a single conditional subtraction.
- Read pipeline:
  - S1 registers sx = px_x >> SCALE_SHIFT, sy = px_y >> SCALE_SHIFT, an out-of-range flag oob = (sx ≥ IMG_W) | (sy ≥ IMG_H), and valid.
  - S2 computes col = sx + scroll_pos, then subtracts IMG_W if col ≥ IMG_W. It then registers addr = active_bank*IMG_W*IMG_H + sy*IMG_W + col, along with oob and valid.
  - S3 performs a registered memory read. pix_out = oob ? 0 : mem[addr], and pix_valid = S2 valid.
- When px_valid is low, the pipeline still advances and pix_valid falls 3 cycles later. pix_out holds its last value while pix_valid is low.
- Read-during-write to the same address returns the old data. The new data is visible on the next read.

## Timing
- Read latency is exactly 3 cycles, with throughput of 1 pixel per cycle and no stalls or backpressure.
- Reset state:
  - pix_out = 0, pix_valid = 0, scroll_pos = 0, active bank = 0.
  - All pipeline valid and oob registers are cleared.
- Reset asserted mid-stream drops every in-flight pixel: pix_valid is 0 on the cycle after reset is sampled. A write in the reset cycle is still performed.
- When frame_tick and px_valid coincide:
  - A pixel sampled in S1 on that edge uses the new scroll_pos and bank, because S2 reads them one edge later.
  - Pixels already in S2 or S3 keep their computed address.
- Consecutive frame_tick pulses each advance the scroll.
- Wrap-around: with IMG_W=160, scroll_pos=150 and step 20, the new scroll_pos is 10.

## Test plan
- Reset, then fill bank 0 with word = address and bank 1 with word = ~address. Sweep the screen with px_valid=1 → pix_out at (x=8, y=4) is 0x00A2 (row 1, col 2), 3 cycles after the coordinate is applied, and pix_valid tracks px_valid delayed by 3.
- Scroll test: scroll_en=1, step=20, pulse frame_tick 8 times → scroll_pos=0 (160 mod 160). At scroll_pos=150, pixel (x=40, y=0) reads col 0 (150+10 wraps).
- Bank switch: set bank_sel=1 without frame_tick → output unchanged. Pulse frame_tick → pixel (0,0) reads 0xFFFF.
- Out-of-range: px_y=480 (sy=120), and separately wr_addr=19200 → pix_out=0 with pix_valid=1, and the memory is unchanged.
- Read-during-write: write 0x1234 to address 5 in the same cycle S2 presents address 5 → old value is output, and a re-read next cycle gives 0x1234.
- Mid-stream reset: assert rst for 1 cycle during a pixel sweep → pix_valid=0 and pix_out=0 the following cycle, scroll_pos=0, and memory contents are intact on re-read.
